// File: rtl/adc_channel_sequencer.sv
// ---------------------------------------------------------------------------
// adc_channel_sequencer
//
// Steps a set of ADC multiplexer lanes through a programmable table of
// channel selections. Each table entry holds one 5-bit select per lane. An
// entry stays selected for `dwell` counted frames. The first frame after every
// selection change is discarded because it may contain lanes that were
// captured under the previous selection.
//
// Optional feature (macro SEQ_TIMEOUT_EN): a per-frame watchdog. If no frame
// arrives within TIMEOUT_CYCLES cycles, it sets a sticky error flag and
// forces the sequence on to the next entry. When the macro is undefined,
// timeout_err is tied low and the sequencer waits for frames indefinitely.
//
// Ports
//   CLK            clock, rising edge
//   rstn           synchronous active-low reset
//   cfg_we         table write strobe (honoured only while idle)
//   cfg_addr       table entry index for writes
//   cfg_data       per-lane selects, lane j in bits [5j+4:5j]
//   seq_len        number of active entries, sampled on start
//   dwell          counted frames per entry, sampled on start
//   start          pulse: begin sequencing from entry 0
//   stop           pulse: abort to idle (highest priority)
//   frame_valid    pulse: one multiplexer output frame completed
//   err_clr        clears timeout_err
//   select_channel registered lane selects to the multiplexer
//   busy           high while sequencing
//   entry_idx      index of the current entry
//   entry_done     pulse when an entry completes its dwell
//   timeout_err    sticky watchdog flag
// ---------------------------------------------------------------------------
module adc_channel_sequencer #(
  parameter int NUM_OF_ADC     = 4,
  parameter int SEQ_DEPTH      = 8,
  parameter int DWELL_WIDTH    = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           CLK,
  input  logic                           rstn,
  input  logic                           cfg_we,
  input  logic [$clog2(SEQ_DEPTH)-1:0]   cfg_addr,
  input  logic [5*NUM_OF_ADC-1:0]        cfg_data,
  input  logic [$clog2(SEQ_DEPTH):0]     seq_len,
  input  logic [DWELL_WIDTH-1:0]         dwell,
  input  logic                           start,
  input  logic                           stop,
  input  logic                           frame_valid,
  input  logic                           err_clr,
  output logic [4:0]                     select_channel [0:NUM_OF_ADC-1],
  output logic                           busy,
  output logic [$clog2(SEQ_DEPTH)-1:0]   entry_idx,
  output logic                           entry_done,
  output logic                           timeout_err
);

  localparam int AW = $clog2(SEQ_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = 5 * NUM_OF_ADC;
  localparam logic [LW-1:0]          DEPTH_L   = LW'(SEQ_DEPTH);
  localparam logic [DWELL_WIDTH-1:0] DWELL_ONE = DWELL_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SKIP = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t                 r_state;
  logic [EW-1:0]          r_table  [0:SEQ_DEPTH-1];
  logic [4:0]             r_select [0:NUM_OF_ADC-1];
  logic [LW-1:0]          r_len;
  logic [DWELL_WIDTH-1:0] r_dwell;
  logic [DWELL_WIDTH-1:0] r_frame_cnt;
  logic [AW-1:0]          r_entry_idx;
  logic                   r_busy;
  logic                   r_entry_done;

  logic [AW-1:0]          w_next_idx;
  logic [EW-1:0]          w_next_entry;
  logic [EW-1:0]          w_first_entry;
  logic                   w_frame_hit;
  logic                   w_timeout;
  logic                   w_advance;

  // Wrap from the last active entry back to entry 0.
  assign w_next_idx    = (({1'b0, r_entry_idx} + LW'(1)) == r_len) ? {AW{1'b0}}
                                                                   : (r_entry_idx + AW'(1));
  assign w_next_entry  = r_table[w_next_idx];
  assign w_first_entry = r_table[0];

  // The frame that completes the dwell; stop suppresses it (no entry_done on abort).
  assign w_frame_hit = (r_state == RUN) && frame_valid && !stop &&
                       ((r_frame_cnt + DWELL_ONE) == r_dwell);
  assign w_advance   = w_frame_hit || w_timeout;

`ifdef SEQ_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

  logic [WW-1:0] r_wd_cnt;
  logic          r_timeout_err;

  // A frame on the same cycle as expiry counts as progress, so it cancels the timeout.
  assign w_timeout = (r_state != IDLE) && !stop && !frame_valid && (r_wd_cnt == WD_LAST);

  // Watchdog: cycles since the last frame or entry change while sequencing.
  always_ff @(posedge CLK) begin
    if (!rstn) begin
      r_wd_cnt <= {WW{1'b0}};
    end else if ((r_state == IDLE) || stop || frame_valid || w_advance) begin
      r_wd_cnt <= {WW{1'b0}};
    end else begin
      r_wd_cnt <= r_wd_cnt + WW'(1);
    end
  end

  // Sticky error flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge CLK) begin
    if (!rstn) begin
      r_timeout_err <= 1'b0;
    end else if (w_timeout) begin
      r_timeout_err <= 1'b1;
    end else if (err_clr) begin
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= r_timeout_err;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  logic w_unused;

  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
  assign w_unused    = err_clr ^ (TIMEOUT_CYCLES == 32'sd0);
`endif

  // Sequencer FSM, table storage and all registered outputs.
  always_ff @(posedge CLK) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_len        <= {LW{1'b0}};
      r_dwell      <= {DWELL_WIDTH{1'b0}};
      r_frame_cnt  <= {DWELL_WIDTH{1'b0}};
      r_entry_idx  <= {AW{1'b0}};
      r_busy       <= 1'b0;
      r_entry_done <= 1'b0;
      for (int i = 0; i < SEQ_DEPTH; i++) begin
        r_table[i] <= {EW{1'b0}};
      end
      for (int j = 0; j < NUM_OF_ADC; j++) begin
        r_select[j] <= 5'd0;
      end
    end else begin
      r_entry_done <= 1'b0;

      // The table is frozen while sequencing so entries cannot change mid-run.
      if ((r_state == IDLE) && cfg_we) begin
        r_table[cfg_addr] <= cfg_data;
      end

      if (stop) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start && (seq_len != {LW{1'b0}})) begin
              r_len       <= (seq_len > DEPTH_L) ? DEPTH_L : seq_len;
              r_dwell     <= (dwell == {DWELL_WIDTH{1'b0}}) ? DWELL_ONE : dwell;
              r_frame_cnt <= {DWELL_WIDTH{1'b0}};
              r_entry_idx <= {AW{1'b0}};
              r_busy      <= 1'b1;
              r_state     <= SKIP;
              for (int j = 0; j < NUM_OF_ADC; j++) begin
                r_select[j] <= w_first_entry[5*j +: 5];
              end
            end
          end

          SKIP, RUN: begin
            if (w_advance) begin
              r_entry_done <= w_frame_hit;
              r_entry_idx  <= w_next_idx;
              r_frame_cnt  <= {DWELL_WIDTH{1'b0}};
              r_state      <= SKIP;
              for (int j = 0; j < NUM_OF_ADC; j++) begin
                r_select[j] <= w_next_entry[5*j +: 5];
              end
            end else if (frame_valid) begin
              // In SKIP the frame is discarded; in RUN it is counted.
              if (r_state == RUN) begin
                r_frame_cnt <= r_frame_cnt + DWELL_ONE;
              end
              r_state <= RUN;
            end
          end

          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign select_channel = r_select;
  assign busy           = r_busy;
  assign entry_idx      = r_entry_idx;
  assign entry_done     = r_entry_done;

endmodule

// File: tb/tb_adc_channel_sequencer.sv
module tb_adc_channel_sequencer;

  localparam int N   = 4;
  localparam int D   = 8;
  localparam int TMO = 16;

  logic        CLK;
  logic        rstn;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [19:0] cfg_data;
  logic [3:0]  seq_len;
  logic [7:0]  dwell;
  logic        start;
  logic        stop;
  logic        frame_valid;
  logic        err_clr;
  logic [4:0]  select_channel [0:N-1];
  logic        busy;
  logic [2:0]  entry_idx;
  logic        entry_done;
  logic        timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  adc_channel_sequencer #(
    .NUM_OF_ADC(N), .SEQ_DEPTH(D), .DWELL_WIDTH(8), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK(CLK), .rstn(rstn), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .seq_len(seq_len), .dwell(dwell), .start(start),
    .stop(stop), .frame_valid(frame_valid), .err_clr(err_clr),
    .select_channel(select_channel), .busy(busy), .entry_idx(entry_idx),
    .entry_done(entry_done), .timeout_err(timeout_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- reference model (abstract: table, index, frame tally) ----
  logic [19:0] m_table [0:D-1];
  logic [4:0]  m_sel   [0:N-1];
  bit m_busy, m_discard, m_done, m_err;
  int m_idx, m_len, m_dwell, m_frames, m_wd;

  task automatic load_sel(input logic [19:0] e);
    for (int j = 0; j < N; j++) m_sel[j] = e[5*j +: 5];
  endtask

  task automatic advance();
    m_idx = (m_idx + 1) % m_len;
    load_sel(m_table[m_idx]);
    m_frames = 0;
    m_discard = 1;
    m_wd = 0;
  endtask

  task automatic model_step();
    bit tmo;
    logic [19:0] t0;
    tmo = 0;
    m_done = 0;
    if (!rstn) begin
      m_busy = 0; m_discard = 0; m_idx = 0; m_len = 0; m_dwell = 0;
      m_frames = 0; m_wd = 0; m_err = 0;
      for (int i = 0; i < D; i++) m_table[i] = '0;
      for (int j = 0; j < N; j++) m_sel[j] = '0;
      return;
    end
    t0 = m_table[0];
    if (!m_busy && cfg_we) m_table[cfg_addr] = cfg_data;
    if (stop) begin
      m_busy = 0;
    end else if (!m_busy) begin
      if (start && seq_len != 0) begin
        m_len   = (seq_len > D) ? D : int'(seq_len);
        m_dwell = (dwell == 0) ? 1 : int'(dwell);
        m_idx = 0; load_sel(t0);
        m_busy = 1; m_discard = 1; m_frames = 0; m_wd = 0;
      end
    end else if (frame_valid) begin
      m_wd = 0;
      if (m_discard) m_discard = 0;
      else begin
        m_frames++;
        if (m_frames == m_dwell) begin m_done = 1; advance(); end
      end
    end else begin
`ifdef SEQ_TIMEOUT_EN
      m_wd++;
      if (m_wd == TMO) begin tmo = 1; advance(); end
`endif
    end
    if (tmo) m_err = 1;
    else if (err_clr) m_err = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("busy", 32'(busy), 32'(m_busy));
    check("entry_idx", 32'(entry_idx), 32'(m_idx));
    check("entry_done", 32'(entry_done), 32'(m_done));
    check("timeout_err", 32'(timeout_err), 32'(m_err));
    for (int j = 0; j < N; j++)
      check($sformatf("sel%0d", j), 32'(select_channel[j]), 32'(m_sel[j]));
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
    compare_all();
  endtask

  task automatic write_entry(input logic [2:0] a, input logic [19:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       fv, st, sp;
    logic [3:0] len;
    logic       exp_busy, exp_done;
    logic [2:0] exp_idx;
    logic [4:0] exp_s0, exp_s3;
  } vec_t;

  vec_t vecs [0:17];

  localparam logic [19:0] E0 = {5'd3, 5'd2, 5'd1, 5'd0};
  localparam logic [19:0] E1 = {5'd11, 5'd10, 5'd9, 5'd8};

  initial begin
    int n;
    bit seen_done;
    logic [2:0] ra;

    //               fv    st    sp    len   busy  done  idx   s0     s3
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 3'd0, 5'd0, 5'd3};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 3'd0, 5'd0, 5'd3};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 3'd0, 5'd0, 5'd3};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 3'd1, 5'd8, 5'd11};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 3'd1, 5'd8, 5'd11};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 3'd1, 5'd8, 5'd11};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 3'd1, 5'd8, 5'd11};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 3'd0, 5'd0, 5'd3};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 3'd0, 5'd0, 5'd3};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 3'd0, 5'd0, 5'd3};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 3'd1, 5'd8, 5'd11};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 3'd1, 5'd8, 5'd11};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 3'd1, 5'd8, 5'd11};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 3'd1, 5'd8, 5'd11};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 3'd1, 5'd8, 5'd11};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 3'd1, 5'd8, 5'd11};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 3'd1, 5'd8, 5'd11};
    vecs[17] = '{1'b0, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 3'd1, 5'd8, 5'd11};

    rstn = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; seq_len = '0;
    dwell = '0; start = 1'b0; stop = 1'b0; frame_valid = 1'b0; err_clr = 1'b0;
    #2;
    tick(); tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_sel0", 32'(select_channel[0]), 32'd0);
    rstn = 1'b1;
    tick();

    // Basic sequencing, stop priority, ignored zero-length start.
    write_entry(3'd0, E0);
    write_entry(3'd1, E1);
    dwell = 8'd2;
    for (int i = 0; i <= 17; i++) begin
      frame_valid = vecs[i].fv; start = vecs[i].st; stop = vecs[i].sp; seq_len = vecs[i].len;
      tick();
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d_done", i), 32'(entry_done), 32'(vecs[i].exp_done));
      check($sformatf("vec%0d_idx", i), 32'(entry_idx), 32'(vecs[i].exp_idx));
      check($sformatf("vec%0d_s0", i), 32'(select_channel[0]), 32'(vecs[i].exp_s0));
      check($sformatf("vec%0d_s3", i), 32'(select_channel[3]), 32'(vecs[i].exp_s3));
    end
    frame_valid = 1'b0; start = 1'b0; stop = 1'b0;

    // Table write while busy must be ignored.
    seq_len = 4'd2; dwell = 8'd1; start = 1'b1; tick(); start = 1'b0;
    write_entry(3'd0, 20'hFFFFF);
    frame_valid = 1'b1;
    repeat (4) tick();
    frame_valid = 1'b0;
    check("busywr_idx", 32'(entry_idx), 32'd0);
    check("busywr_s0", 32'(select_channel[0]), 32'd0);
    check("busywr_s1", 32'(select_channel[1]), 32'd1);
    check("busywr_s3", 32'(select_channel[3]), 32'd3);
    stop = 1'b1; tick(); stop = 1'b0;

    // Reset in RUN with entry_idx = 1.
    seq_len = 4'd2; dwell = 8'd3; start = 1'b1; tick(); start = 1'b0;
    frame_valid = 1'b1;
    repeat (5) tick();
    frame_valid = 1'b0;
    check("pre_rst_idx", 32'(entry_idx), 32'd1);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rstn = 1'b0; tick(); rstn = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_idx", 32'(entry_idx), 32'd0);
    check("rst_done", 32'(entry_done), 32'd0);
    check("rst_err", 32'(timeout_err), 32'd0);
    check("rst_s1", 32'(select_channel[1]), 32'd0);
    // Entry 1 was cleared by reset: advancing to it must select channel 0.
    seq_len = 4'd2; dwell = 8'd1; start = 1'b1; tick(); start = 1'b0;
    frame_valid = 1'b1; repeat (2) tick(); frame_valid = 1'b0;
    check("rst_tbl_idx", 32'(entry_idx), 32'd1);
    check("rst_tbl_s0", 32'(select_channel[0]), 32'd0);
    check("rst_tbl_s3", 32'(select_channel[3]), 32'd0);
    stop = 1'b1; tick(); stop = 1'b0;

    // Watchdog behaviour with no frames.
    write_entry(3'd0, E0);
    write_entry(3'd1, E1);
    seq_len = 4'd2; dwell = 8'd1; start = 1'b1; tick(); start = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    n = 0; seen_done = 0;
    while (n < 40 && timeout_err !== 1'b1) begin
      tick(); n++;
      if (entry_done === 1'b1) seen_done = 1;
    end
    check("tmo_latency", 32'(n), 32'(TMO));
    check("tmo_idx", 32'(entry_idx), 32'd1);
    check("tmo_s0", 32'(select_channel[0]), 32'd8);
    check("tmo_no_done", 32'(seen_done), 32'd0);
    err_clr = 1'b1; tick();
    check("tmo_clr", 32'(timeout_err), 32'd0);
    repeat (TMO - 1) tick();
    check("tmo_beats_clr", 32'(timeout_err), 32'd1);
    check("tmo_idx2", 32'(entry_idx), 32'd0);
    err_clr = 1'b0;
`else
    repeat (40) tick();
    check("notmo_err", 32'(timeout_err), 32'd0);
    check("notmo_busy", 32'(busy), 32'd1);
    check("notmo_idx", 32'(entry_idx), 32'd0);
`endif
    stop = 1'b1; tick(); stop = 1'b0;

    // Randomized traffic against the model, in sparse- and dense-frame phases.
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 1000; c++) begin
        rstn        = ($urandom_range(0, 599) != 0);
        cfg_we      = ($urandom_range(0, 3) == 0);
        ra          = 3'($urandom);
        cfg_addr    = ra;
        cfg_data    = 20'($urandom);
        start       = ($urandom_range(0, 19) == 0);
        seq_len     = 4'($urandom_range(0, 15));
        dwell       = 8'($urandom_range(0, 3));
        stop        = ($urandom_range(0, 149) == 0);
        frame_valid = (ph[0] ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) == 0));
        err_clr     = ($urandom_range(0, 30) == 0);
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adc_channel_sequencer.md
ADC_CHANNEL_SEQUENCER -- requirements
Module: adc_channel_sequencer

Interface
REQ-001 Parameter NUM_OF_ADC, default 4: number of output lanes driven; one 5-bit channel select per lane.
REQ-002 Parameter SEQ_DEPTH, default 8: number of sequence table entries.
REQ-003 Parameter DWELL_WIDTH, default 8: width of the frames-per-entry count.
REQ-004 Parameter TIMEOUT_CYCLES, default 1024: frame watchdog limit, used only when SEQ_TIMEOUT_EN is defined.
REQ-005 CLK  input  1  clock; all logic on the rising edge.
REQ-006 rstn  input  1  reset, synchronous, active-low.
REQ-007 cfg_we  input  1  table write strobe.
REQ-008 cfg_addr  input  $clog2(SEQ_DEPTH)  table entry index.
REQ-009 cfg_data  input  5*NUM_OF_ADC  channel selects for one entry; lane j is bits [5j+4:5j].
REQ-010 seq_len  input  $clog2(SEQ_DEPTH)+1  active entry count; sampled on start.
REQ-011 dwell  input  DWELL_WIDTH  counted frames per entry; sampled on start.
REQ-012 start  input  1  single-cycle pulse that begins sequencing.
REQ-013 stop  input  1  single-cycle pulse that aborts sequencing.
REQ-014 frame_valid  input  1  one-cycle pulse per completed multiplexer output frame (downstream tvalid).
REQ-015 select_channel  output  array [0:NUM_OF_ADC-1] of 5 bits  lane selects to the multiplexer; registered.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 entry_idx  output  $clog2(SEQ_DEPTH)  index of the current entry.
REQ-018 entry_done  output  1  one-cycle pulse when an entry finishes its dwell.
REQ-019 timeout_err  output  1  sticky watchdog flag.
REQ-020 err_clr  input  1  clears timeout_err.

Function
REQ-021 The FSM SHALL have states IDLE, SKIP and RUN.
REQ-022 In IDLE, a write with cfg_we=1 SHALL store cfg_data at cfg_addr; while busy=1, cfg_we SHALL be ignored.
REQ-023 start in IDLE with seq_len!=0 SHALL latch seq_len and dwell, set entry_idx=0, load select_channel from entry 0 on the next edge, and enter SKIP.
REQ-024 start with seq_len=0, or start while busy, SHALL be ignored.
REQ-025 seq_len>SEQ_DEPTH SHALL be clamped to SEQ_DEPTH; dwell=0 SHALL be treated as 1.
REQ-026 In SKIP, the first frame_valid SHALL be discarded because it may carry lanes captured under the previous selection; the FSM then enters RUN.
REQ-027 In RUN, each frame_valid SHALL increment the frame counter.
REQ-028 On the frame_valid that brings the counter to dwell, the block SHALL pulse entry_done, increment entry_idx (wrapping from seq_len-1 to 0), load the new selects in that same edge, clear the counter, and enter SKIP.
REQ-029 select_channel SHALL change only on entry advance, and SHALL keep its last value in IDLE.
REQ-030 stop SHALL return the FSM to IDLE on the next edge, with no entry_done pulse; stop SHALL take priority over simultaneous start, frame_valid or timeout.
REQ-031 err_clr SHALL clear timeout_err; a timeout in the same cycle as err_clr SHALL win and leave the flag set.

Reset
REQ-032 While rstn=0 at an edge, the block SHALL set: state IDLE, entry_idx 0, all select_channel 0, all table entries 0, counters 0, entry_done 0, timeout_err 0, busy 0.
REQ-033 Reset asserted during SKIP or RUN SHALL abort immediately, with no entry_done pulse.

Configuration
REQ-034 With macro SEQ_TIMEOUT_EN defined, a cycle counter SHALL run in SKIP and RUN, clearing on each frame_valid and on each entry advance; on reaching TIMEOUT_CYCLES it SHALL set timeout_err and advance the entry as in REQ-028, without an entry_done pulse.
REQ-035 With SEQ_TIMEOUT_EN undefined, there SHALL be no watchdog logic, timeout_err SHALL be tied to 0, and the FSM SHALL wait for frame_valid indefinitely.

Verification
REQ-036 Write entries 0={0,1,2,3} and 1={8,9,10,11}; seq_len=2, dwell=2; start; send 9 frames -> entry_done pulses after frames 3, 6 and 9, and select_channel alternates entry 1, entry 0, entry 1.
REQ-037 seq_len=0 and start -> busy stays 0 and select_channel is unchanged.
REQ-038 Assert stop and frame_valid in the same cycle during RUN -> IDLE next cycle, no entry_done, selects held.
REQ-039 cfg_we to entry 0 while busy -> table content unchanged, as seen after the sequence next returns to entry 0.
REQ-040 With SEQ_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, and no frames -> timeout_err rises 16 cycles after SKIP entry and entry_idx advances; err_clr then clears the flag.
REQ-041 Reset asserted in RUN with entry_idx=1 -> all outputs at their reset values on the next cycle.
